// File: rtl/i2s_tx.sv
// Philips I2S master transmitter: a FIFO of stereo pairs feeds the SCK/WS/SD serialiser.
// SD and WS change only on SCK falling edges or at a frame load.
module i2s_tx #(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        enable,
    input  logic [SAMPLE_W-1:0]         sample_l,
    input  logic [SAMPLE_W-1:0]         sample_r,
    input  logic                        sample_valid,
    output logic                        sample_ready,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        underrun,
    input  logic                        underrun_clr,
    output logic                        SCK,
    output logic                        WS,
    output logic                        SD
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned B_W   = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [B_W-1:0]   B_LAST   = B_W'(2 * SLOT_W - 1);
    localparam logic [B_W-1:0]   R_FIRST  = B_W'(SLOT_W);
    localparam logic [B_W-1:0]   WS_FIRST = B_W'(SLOT_W - 1);
    localparam logic [B_W-1:0]   WS_LAST  = B_W'(2 * SLOT_W - 2);
    localparam logic [LVL_W-1:0] FULL     = LVL_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] mem_l [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                ready_q, underrun_q;
    logic [DIV_W-1:0]    div_q;
    logic [B_W-1:0]      b_q, b_inc_c;
    logic                sck_q, ws_q, sd_q;
    logic [SAMPLE_W-1:0] l_sh_q, r_sh_q;
    logic                tc_c, load_c, fall_c, run_c, push_c, pop_c, empty_c;

    // WS leads each slot's MSB by one bit and covers the right slot otherwise
    function automatic logic ws_at(input logic [B_W-1:0] bi);
        return (bi >= WS_FIRST) && (bi <= WS_LAST);
    endfunction

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        fall_c  = 1'b0;
        run_c   = 1'b0;
        tc_c    = (div_q == DIV_LAST);
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    load_c  = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    run_c  = 1'b1;
                    fall_c = tc_c && sck_q;
                    load_c = fall_c && (b_q == B_LAST);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign empty_c = (level_q == '0);
    assign push_c  = sample_valid && ready_q;
    assign pop_c   = load_c && !empty_c;
    assign b_inc_c = b_q + B_W'(1);

    always_comb begin
        level_d = level_q;
        if (push_c && !pop_c)      level_d = level_q + LVL_W'(1);
        else if (!push_c && pop_c) level_d = level_q - LVL_W'(1);
    end

    // FIFO bookkeeping and sticky underrun (set wins over clear)
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_q    <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
            ready_q <= (level_d != FULL);
            if (load_c && empty_c) underrun_q <= 1'b1;
            else if (underrun_clr) underrun_q <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (push_c) begin
            mem_l[wr_ptr_q] <= sample_l;
            mem_r[wr_ptr_q] <= sample_r;
        end
    end

    // Serialiser: shift registers fill with zeros, which also pads each slot
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sck_q  <= 1'b0;
            ws_q   <= 1'b0;
            sd_q   <= 1'b0;
            div_q  <= '0;
            b_q    <= '0;
            l_sh_q <= '0;
            r_sh_q <= '0;
        end else if (load_c) begin
            sck_q <= 1'b0;
            div_q <= '0;
            b_q   <= '0;
            ws_q  <= ws_at('0);
            if (pop_c) begin
                sd_q   <= mem_l[rd_ptr_q][SAMPLE_W-1];
                l_sh_q <= mem_l[rd_ptr_q] << 1;
                r_sh_q <= mem_r[rd_ptr_q];
            end else begin
                sd_q   <= 1'b0;
                l_sh_q <= '0;
                r_sh_q <= '0;
            end
        end else if (run_c) begin
            if (tc_c) begin
                sck_q <= ~sck_q;
                div_q <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
            if (fall_c) begin
                b_q  <= b_inc_c;
                ws_q <= ws_at(b_inc_c);
                if (b_inc_c < R_FIRST) begin
                    sd_q   <= l_sh_q[SAMPLE_W-1];
                    l_sh_q <= l_sh_q << 1;
                end else begin
                    sd_q   <= r_sh_q[SAMPLE_W-1];
                    r_sh_q <= r_sh_q << 1;
                end
            end
        end else begin
            sck_q <= 1'b0;
            ws_q  <= 1'b0;
            sd_q  <= 1'b0;
            div_q <= '0;
            b_q   <= '0;
        end
    end

    assign sample_ready = ready_q;
    assign level        = level_q;
    assign underrun     = underrun_q;
    assign SCK          = sck_q;
    assign WS           = ws_q;
    assign SD           = sd_q;
endmodule
